// File: rtl/affinex_pkg.sv
// Shared types and constants for the affine-transform line rasterizer.
package affinex_pkg;

    // Default signed coordinate width (pixel in/out).
    localparam int unsigned DEF_COORD_W = 16;

    typedef logic signed [DEF_COORD_W-1:0] coord_t;
    typedef logic signed [DEF_COORD_W+1:0] err_t;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StDraw
    } raster_state_e;

    // Vertex command encoding on in_move_i.
    localparam logic CMD_MOVE = 1'b1;
    localparam logic CMD_LINE = 1'b0;

endpackage

// File: rtl/affinex_bresenham_step.sv
// One combinational Bresenham step: advances the pen by at most one pixel
// in x and/or y and updates the error term. Shared by setup and draw.
module affinex_bresenham_step #(
    parameter int unsigned COORD_W = 16
) (
    input  logic signed [COORD_W-1:0] pos_x_i,
    input  logic signed [COORD_W-1:0] pos_y_i,
    input  logic signed [COORD_W+1:0] err_i,
    input  logic signed [COORD_W:0]   dx_i,
    input  logic signed [COORD_W:0]   dy_i,
    input  logic                      sx_neg_i,
    input  logic                      sy_neg_i,
    output logic signed [COORD_W-1:0] pos_x_o,
    output logic signed [COORD_W-1:0] pos_y_o,
    output logic signed [COORD_W+1:0] err_o
);

    logic signed [COORD_W+2:0] e2;
    logic signed [COORD_W+2:0] dx_ext;
    logic signed [COORD_W+2:0] dy_ext;
    logic                      step_x;
    logic                      step_y;

    assign e2     = {err_i, 1'b0};
    assign dx_ext = {{2{dx_i[COORD_W]}}, dx_i};
    assign dy_ext = {{2{dy_i[COORD_W]}}, dy_i};
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);

    // Both axis updates use the same pre-step e2.
    always_comb begin
        err_o   = err_i;
        pos_x_o = pos_x_i;
        pos_y_o = pos_y_i;
        if (step_x) begin
            err_o   = err_o + {dy_i[COORD_W], dy_i};
            pos_x_o = sx_neg_i ? pos_x_i - COORD_W'(1) : pos_x_i + COORD_W'(1);
        end
        if (step_y) begin
            err_o   = err_o + {dx_i[COORD_W], dx_i};
            pos_y_o = sy_neg_i ? pos_y_i - COORD_W'(1) : pos_y_i + COORD_W'(1);
        end
    end

endmodule

// File: rtl/affinex_line_raster.sv
// Streaming Bresenham line rasterizer: move-to / line-to vertices in,
// one pixel per cycle out with valid/ready. Joint pixels of a polyline are
// emitted once because each line-to skips its start pixel.
// Optional screen clipping is enabled by defining AFFINEX_CLIP_EN.
module affinex_line_raster
    import affinex_pkg::*;
#(
    parameter int unsigned COORD_W   = DEF_COORD_W,
    parameter int unsigned FRAC_BITS = 0,
    parameter int unsigned SCR_W     = 320,
    parameter int unsigned SCR_H     = 240
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      in_move_i,
    input  logic signed [COORD_W-1:0] in_x_i,
    input  logic signed [COORD_W-1:0] in_y_i,
    output logic                      px_valid_o,
    input  logic                      px_ready_i,
    output logic signed [COORD_W-1:0] px_x_o,
    output logic signed [COORD_W-1:0] px_y_o,
    output logic                      px_last_o,
    output logic                      seg_done_o,
    output logic                      busy_o,
    output logic [15:0]               clip_cnt_o
);

`ifdef AFFINEX_CLIP_EN
    localparam bit ClipEn = 1'b1;
`else
    localparam bit ClipEn = 1'b0;
`endif

    typedef logic signed [COORD_W-1:0] crd_t;
    typedef logic signed [COORD_W:0]   dlt_t;
    typedef logic signed [COORD_W+1:0] acc_t;

    raster_state_e state_q, state_d;
    crd_t  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    crd_t  tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    crd_t  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    dlt_t  dx_q, dx_d, dy_q, dy_d;
    acc_t  err_q, err_d;
    logic  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic  move_q, move_d;
    logic [15:0] clip_cnt_q, clip_cnt_d;

    crd_t  in_px_x, in_px_y, step_x, step_y;
    dlt_t  diff_x, diff_y, abs_x, abs_y;
    acc_t  step_err;
    logic  at_target, off_screen, clipped, advance;

    assign in_px_x   = in_x_i >>> FRAC_BITS;
    assign in_px_y   = in_y_i >>> FRAC_BITS;
    assign diff_x    = {in_px_x[COORD_W-1], in_px_x} - {cur_x_q[COORD_W-1], cur_x_q};
    assign diff_y    = {in_px_y[COORD_W-1], in_px_y} - {cur_y_q[COORD_W-1], cur_y_q};
    assign abs_x     = diff_x[COORD_W] ? -diff_x : diff_x;
    assign abs_y     = diff_y[COORD_W] ? -diff_y : diff_y;
    assign at_target = (pos_x_q == tgt_x_q) && (pos_y_q == tgt_y_q);
    assign off_screen = (int'(pos_x_q) < 0) || (int'(pos_x_q) >= int'(SCR_W)) ||
                        (int'(pos_y_q) < 0) || (int'(pos_y_q) >= int'(SCR_H));
    // A clipped pixel consumes its draw cycle without a handshake.
    assign clipped   = ClipEn && (state_q == StDraw) && off_screen;
    assign advance   = clipped || px_ready_i;

    affinex_bresenham_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .pos_x_i  (pos_x_q),
        .pos_y_i  (pos_y_q),
        .err_i    (err_q),
        .dx_i     (dx_q),
        .dy_i     (dy_q),
        .sx_neg_i (sx_neg_q),
        .sy_neg_i (sy_neg_q),
        .pos_x_o  (step_x),
        .pos_y_o  (step_y),
        .err_o    (step_err)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid_i) state_d = StSetup;
            StSetup: if (!move_q && at_target) state_d = StIdle;
                     else                      state_d = StDraw;
            StDraw:  if (advance && at_target) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; no added latency.
    always_comb begin
        in_ready_o = (state_q == StIdle);
        busy_o     = (state_q != StIdle);
        px_valid_o = (state_q == StDraw) && !clipped;
        px_last_o  = px_valid_o && at_target;
        seg_done_o = ((state_q == StSetup) && !move_q && at_target) ||
                     ((state_q == StDraw) && at_target && advance);
        px_x_o     = pos_x_q;
        px_y_o     = pos_y_q;
        clip_cnt_o = ClipEn ? clip_cnt_q : 16'h0000;
    end

    // Segment datapath: latch the command, pre-step, then step per pixel.
    always_comb begin
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        err_d      = err_q;
        sx_neg_d   = sx_neg_q;
        sy_neg_d   = sy_neg_q;
        move_d     = move_q;
        clip_cnt_d = clip_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    tgt_x_d  = in_px_x;
                    tgt_y_d  = in_px_y;
                    dx_d     = abs_x;
                    dy_d     = -abs_y;
                    sx_neg_d = diff_x[COORD_W];
                    sy_neg_d = diff_y[COORD_W];
                    err_d    = {abs_x[COORD_W], abs_x} - {abs_y[COORD_W], abs_y};
                    pos_x_d  = cur_x_q;
                    pos_y_d  = cur_y_q;
                    move_d   = (in_move_i == CMD_MOVE);
                end
            end
            StSetup: begin
                if (move_q) begin
                    pos_x_d = tgt_x_q;
                    pos_y_d = tgt_y_q;
                end else if (!at_target) begin
                    // Start pixel is the previous segment's end; skip it.
                    pos_x_d = step_x;
                    pos_y_d = step_y;
                    err_d   = step_err;
                end
            end
            StDraw: begin
                if (advance) begin
                    if (at_target) begin
                        cur_x_d = tgt_x_q;
                        cur_y_d = tgt_y_q;
                    end else begin
                        pos_x_d = step_x;
                        pos_y_d = step_y;
                        err_d   = step_err;
                    end
                end
                if (clipped && (clip_cnt_q != 16'hFFFF)) clip_cnt_d = clip_cnt_q + 16'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            err_q      <= '0;
            sx_neg_q   <= 1'b0;
            sy_neg_q   <= 1'b0;
            move_q     <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            err_q      <= err_d;
            sx_neg_q   <= sx_neg_d;
            sy_neg_q   <= sy_neg_d;
            move_q     <= move_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

endmodule
